// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port CHIP-8 RAM: the CPU gets the full 12-bit space and the
// screen scanout gets read-only access to the framebuffer window. At most one access is issued per cycle.
module mem_arbiter #(
    parameter logic [11:0] FB_BASE  = 12'h100,
    parameter bit          SCR_PRIO = 1'b0,
    parameter int          STALL_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [11:0]        cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic               cpu_gnt,
    output logic               cpu_rvalid,
    output logic [7:0]         cpu_rdata,
    input  logic               scr_req,
    input  logic [7:0]         scr_off,
    output logic               scr_gnt,
    output logic               scr_rvalid,
    output logic [7:0]         scr_rdata,
    output logic [11:0]        mem_addr,
    output logic               mem_we,
    output logic [7:0]         mem_wdata,
    input  logic [7:0]         mem_rdata,
    output logic [STALL_W-1:0] cpu_stall_cnt
);

    logic               last_scr_p1;
    logic               cpu_vld_p1;
    logic               scr_vld_p1;
    logic [11:0]        addr_hold_p1;
    logic [STALL_W-1:0] stall_p1;
    logic               cpu_wins;
    logic [11:0]        scr_addr;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + STALL_W'(1);
    endfunction

    // Stage 0: grant decision and address mux, all combinational.
    always_comb begin
        cpu_wins = SCR_PRIO ? 1'b0 : last_scr_p1;
        cpu_gnt  = rst_n && cpu_req && (!scr_req || cpu_wins);
        scr_gnt  = rst_n && scr_req && (!cpu_req || !cpu_wins);
        scr_addr = FB_BASE + {4'b0000, scr_off};
    end

    always_comb begin
        mem_addr  = addr_hold_p1;
        mem_we    = 1'b0;
        mem_wdata = cpu_wdata;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_we   = cpu_we;
        end else if (scr_gnt) begin
            mem_addr = scr_addr;
        end
    end

    // Stage 1: the RAM returns data one cycle after the address.
    always_ff @(posedge clk) begin
        addr_hold_p1 <= mem_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_scr_p1 <= 1'b1;
            cpu_vld_p1  <= 1'b0;
            scr_vld_p1  <= 1'b0;
            stall_p1    <= '0;
        end else begin
            if (cpu_gnt) begin
                last_scr_p1 <= 1'b0;
            end else if (scr_gnt) begin
                last_scr_p1 <= 1'b1;
            end
            cpu_vld_p1 <= cpu_gnt && !cpu_we;
            scr_vld_p1 <= scr_gnt;
            if (cpu_req && !cpu_gnt) begin
                stall_p1 <= sat_inc(stall_p1);
            end
        end
    end

    assign cpu_rvalid    = cpu_vld_p1;
    assign scr_rvalid    = scr_vld_p1;
    assign cpu_rdata     = mem_rdata;
    assign scr_rdata     = mem_rdata;
    assign cpu_stall_cnt = stall_p1;

endmodule
